// File: rtl/spike_fanin_aggregator_if.sv
// Spike-frame, config-write and current-bus signals of spike_fanin_aggregator.
// The master modport is the driving environment; the slave modport is the aggregator.
interface spike_fanin_aggregator_if #(
   parameter int N = 4,
   parameter int W = 8
) ();
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic            spike_valid;
   logic [N-1:0]    spike_vec;
   logic            spike_ready;
   logic            cfg_we;
   logic [IW-1:0]   cfg_src;
   logic [IW-1:0]   cfg_dst;
   logic            cfg_conn;
   logic [W-1:0]    cfg_weight;
   logic [N*W-1:0]  current_out;
   logic            current_valid;
   logic            current_ready;

   modport master (
      output spike_valid, spike_vec, cfg_we, cfg_src, cfg_dst, cfg_conn, cfg_weight,
             current_ready,
      input  spike_ready, current_out, current_valid
   );

   modport slave (
      input  spike_valid, spike_vec, cfg_we, cfg_src, cfg_dst, cfg_conn, cfg_weight,
             current_ready,
      output spike_ready, current_out, current_valid
   );
endinterface

// File: rtl/spike_fanin_aggregator.sv
// Latches a spike frame, scans the [src][dst] adjacency matrix one source row per cycle
// and presents per-target summed currents. Define SPIKE_AGG_SATURATE_EN for clamping adds.
module spike_fanin_aggregator #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   spike_fanin_aggregator_if.slave bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  src_idx_q, src_idx_d;
   logic [N-1:0]   spikes_q, spikes_d;
   logic [W-1:0]   acc_q [N];
   logic [W-1:0]   acc_d [N];
   logic [N-1:0]   conn_q [N];
   logic [N-1:0]   conn_d [N];
   logic [W-1:0]   weight_q [N][N];
   logic [W-1:0]   weight_d [N][N];

   function automatic logic [W-1:0] acc_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
`ifdef SPIKE_AGG_SATURATE_EN
      if (sum[W]) begin
         acc_add = {W{1'b1}};
      end else begin
         acc_add = sum[W-1:0];
      end
`else
      acc_add = sum[W-1:0];
`endif
   endfunction

   // Frame FSM: accept, N-cycle scan with parallel per-target accumulate, hold until consumed.
   always_comb begin
      state_d   = state_q;
      src_idx_d = src_idx_q;
      spikes_d  = spikes_q;
      acc_d     = acc_q;
      case (state_q)
         IDLE: begin
            if (bus.spike_valid) begin
               spikes_d  = bus.spike_vec;
               src_idx_d = {IW{1'b0}};
               for (int j = 0; j < N; j++) begin
                  acc_d[j] = {W{1'b0}};
               end
               state_d = SCAN;
            end else begin
               state_d = IDLE;
            end
         end
         SCAN: begin
            // Diagonal is never summed, whatever the stored conn bit says.
            for (int j = 0; j < N; j++) begin
               if (spikes_q[src_idx_q] && conn_q[src_idx_q][j] && (IW'(j) != src_idx_q)) begin
                  acc_d[j] = acc_add(acc_q[j], weight_q[src_idx_q][j]);
               end else begin
                  acc_d[j] = acc_q[j];
               end
            end
            if (src_idx_q == IW'(N - 1)) begin
               state_d = DONE;
            end else begin
               src_idx_d = src_idx_q + IW'(1);
            end
         end
         DONE: begin
            if (bus.current_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Matrix write port; the scan reads the registered copy, so same-cycle writes are not seen.
   always_comb begin
      conn_d   = conn_q;
      weight_d = weight_q;
      if (bus.cfg_we) begin
         conn_d[bus.cfg_src][bus.cfg_dst]   = bus.cfg_conn;
         weight_d[bus.cfg_src][bus.cfg_dst] = bus.cfg_weight;
      end else begin
         conn_d   = conn_q;
         weight_d = weight_q;
      end
   end

   // State, datapath and matrix registers; reset clears everything including the matrix.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         src_idx_q <= {IW{1'b0}};
         spikes_q  <= {N{1'b0}};
         for (int i = 0; i < N; i++) begin
            acc_q[i]  <= {W{1'b0}};
            conn_q[i] <= {N{1'b0}};
            for (int j = 0; j < N; j++) begin
               weight_q[i][j] <= {W{1'b0}};
            end
         end
      end else begin
         state_q   <= state_d;
         src_idx_q <= src_idx_d;
         spikes_q  <= spikes_d;
         acc_q     <= acc_d;
         conn_q    <= conn_d;
         weight_q  <= weight_d;
      end
   end

   assign bus.spike_ready   = (state_q == IDLE);
   assign bus.current_valid = (state_q == DONE);

   for (genvar g = 0; g < N; g++) begin : g_out
      assign bus.current_out[g*W +: W] = acc_q[g];
   end
endmodule

// File: doc/spike_fanin_aggregator.md
# spike_fanin_aggregator

- Sits directly upstream of the per-neuron accumulate stage in the Izhikevich core.
- Latches one frame of spikes from N neurons and walks an on-chip adjacency matrix, one source row per cycle.
- Sums the programmed synaptic weights of every spiking source into a per-target input current.
- Presents the N currents as one bus with a valid/ready handshake to the downstream adder stage.

## Interface
Parameters:
- `N`, 4, number of neurons (sources = targets); power of two, 2..16
- `W`, 8, weight and current width in bits, unsigned

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `spike_valid`  in  1  spike frame offered
- `spike_vec`  in  N  bit i = neuron i fired this timestep
- `spike_ready`  out  1  frame accepted when high with spike_valid
- `cfg_we`  in  1  write one matrix entry
- `cfg_src`  in  clog2(N)  source index of write
- `cfg_dst`  in  clog2(N)  target index of write
- `cfg_conn`  in  1  connection enable bit written
- `cfg_weight`  in  W  weight written
- `current_out`  out  N*W  target j current at bits [j*W +: W]
- `current_valid`  out  1  current_out holds a completed frame
- `current_ready`  in  1  downstream consumes frame

## Operation
- Storage: N×N connection bits and N×N weights, registers indexed [src][dst].
- Diagonal entries (src == dst) are writable but always treated as disconnected; there is no self-input.
- FSM states:
  - IDLE: spike_ready=1. On spike_valid&&spike_ready: latch spike_vec, clear all N accumulators, set src_idx=0, go to SCAN.
  - SCAN: spike_ready=0. Each cycle, if latched spike[src_idx]=1, then for every dst with conn[src_idx][dst]=1 and dst≠src_idx, acc[dst] += weight[src_idx][dst]. All dst update in parallel. When src_idx=N-1, go to DONE; otherwise increment src_idx.
  - DONE: current_valid=1, current_out=acc. On current_ready, go to IDLE.
- Scan length is always exactly N cycles. Non-spiking rows are not skipped, so latency is deterministic.
- Arithmetic: unsigned W-bit. Overflow behaviour is set by the macro under Configuration.
- Config writes:
  - Accepted in any state and visible from the next cycle.
  - A write to the row being scanned in the same cycle: the scan uses the old value.
  - A write to a row already scanned affects the next frame only.
- current_out is held stable throughout DONE. Accumulators are not modified outside SCAN.
- Reset, including mid-SCAN or DONE, forces:
  - state IDLE
  - src_idx 0
  - all accumulators 0
  - all conn bits 0
  - all weights 0

## Timing
- Reset values: spike_ready=1, current_valid=0, current_out=0.
- Handshake accepted at edge T: SCAN rows 0..N-1 are processed on edges T+1..T+N.
- current_valid rises after edge T+N and is visible in cycle T+N+1. Latency from accept to valid is N+1 cycles.
- current_valid is cleared on the edge where current_valid&&current_ready.
- spike_ready is 1 on the following cycle (IDLE).
- Earliest next accept is one cycle later, giving throughput of one frame per N+2 cycles with current_ready tied high.
- current_ready held low leaves the block in DONE indefinitely. spike_valid is ignored meanwhile, and spike_vec is not sampled.
- spike_valid outside IDLE has no effect. The frame is not queued.

## Configuration
- Macro `SPIKE_AGG_SATURATE_EN`.
- Defined: each accumulate clamps at 2^W−1 (255 for W=8). Once saturated, the value stays saturated for the rest of the frame.
- Undefined: accumulators wrap modulo 2^W.

## Test plan
- **Reset values:** Reset asserted 2 cycles, then deasserted → spike_ready=1, current_valid=0, current_out=0, and an all-ones frame yields currents all 0 (matrix cleared).
- **Basic fan-in:** N=4. Program conn[0][1]=1 w=10, conn[2][1]=1 w=5, conn[0][3]=1 w=7. Send spike_vec=4'b0101 → valid exactly 5 cycles after accept; currents dst0=0, dst1=15, dst2=0, dst3=7.
- **Diagonal ignored:** Program conn[2][2]=1 w=50 and send spike_vec=4'b0100 → dst2=0.
- **Overflow:** conn[0][1] w=200 and conn[3][1] w=100, spike_vec=4'b1001 → dst1=255 with `SPIKE_AGG_SATURATE_EN` defined, dst1=44 without it.
- **Backpressure:** Hold current_ready=0 for 10 cycles after valid, toggling spike_valid with new vectors → current_out unchanged, spike_ready=0 throughout. Release ready → IDLE next cycle, then the next frame is accepted and computed from the new spike_vec.
- **Reset mid-operation:** Pulse reset on the 2nd SCAN cycle → the next cycle shows IDLE, spike_ready=1, current_valid=0. A subsequent frame with spike_vec=4'b1111 gives all currents 0.
